generic_sram_1rw1r: RTL and testbench

- Parametrised single-clock SRAM behavioural model with one read/write port (port 0) and one read-only port (port 1). Successor to the fixed 32x256 byte-masked macro model.
- Adds generic width, depth and lane size, and selectable read latency.
- Adds deterministic same-address write/read collision handling, read-valid strobes, and an optional hardware zero-initialisation sweep after reset.
- Used as the drop-in memory for core instruction/data stores and FIFOs in simulation and FPGA builds.

---
 rtl/generic_sram_pkg.sv | 36 +++
 rtl/generic_sram_1rw1r_rd_pipe.sv | 34 +++
 rtl/generic_sram_1rw1r.sv | 123 ++++++++++++
 tb/tb_generic_sram_1rw1r.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/generic_sram_pkg.sv
// Shared types and helpers for the generic 1RW+1R SRAM model.
// The write path and the collision bypass both use lane_merge, so the two cannot disagree.
package generic_sram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } sram_state_e;

  // Widest word the lane merge handles; callers cast to their own width.
  localparam int MAX_DW = 1024;

  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_DW-1:0] mask,
    input int                num_lanes,
    input int                lane_w
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < num_lanes && i < MAX_DW; i++) begin
      if (mask[i]) begin
        for (int b = 0; b < lane_w; b++) begin
          if (i * lane_w + b < MAX_DW) res[i*lane_w+b] = new_w[i*lane_w+b];
        end
      end
    end
    return res;
  endfunction

  function automatic bit read_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/generic_sram_1rw1r_rd_pipe.sv
// Read data/valid delay line: READ_LATENCY register stages, data held while no valid passes.
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      if (valid_i) dat_q[0] <= data_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[READ_LATENCY-1];
  assign data_o  = dat_q[READ_LATENCY-1];

endmodule

// File: rtl/generic_sram_1rw1r.sv
// Parametrised single-clock SRAM: port 0 read/write with lane mask, port 1 read-only,
// optional zero-fill sweep after reset. Requests: a port acts at a posedge when its csb is low.
module generic_sram_1rw1r
  import generic_sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int NUM_WMASKS   = DATA_WIDTH / BYTE_WIDTH,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter bit BYPASS       = 1'b1,
  parameter bit INIT_ZERO    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_busy,
  output sram_state_e           dbg_state_o
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("generic_sram_1rw1r: READ_LATENCY must be 1 or 2");
  end

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_W  = ADDR_WIDTH'(DEPTH - 1);

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  run, in_rng0, in_rng1;
  logic                  wr_en, rd0_en, rd1_en, collide;
  logic [DATA_WIDTH-1:0] old0, old1, wr_merged, rd1_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_W) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_ZERO ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy   = (state_q == ST_INIT);
  assign dbg_state_o = state_q;

  assign run     = (state_q == ST_RUN) && !rst;
  assign in_rng0 = ({1'b0, addr0} < DEPTH_W);
  assign in_rng1 = ({1'b0, addr1} < DEPTH_W);
  assign wr_en   = run && !csb0 && !web0 && in_rng0;
  assign rd0_en  = run && !csb0 && web0;
  assign rd1_en  = run && !csb1;

  // Out-of-range reads return zero rather than touching a non-existent word.
  assign old0 = in_rng0 ? mem_q[addr0] : '0;
  assign old1 = in_rng1 ? mem_q[addr1] : '0;

  assign wr_merged = DATA_WIDTH'(lane_merge(MAX_DW'(old0), MAX_DW'(din0), MAX_DW'(wmask0),
                                            NUM_WMASKS, BYTE_WIDTH));
  assign collide   = wr_en && !csb1 && (addr1 == addr0);
  assign rd1_data  = (collide && BYPASS) ? wr_merged : old1;

  // Contents are deliberately untouched by rst; only the sweep clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) mem_q[cnt_q] <= '0;
      else if (wr_en) mem_q[addr0] <= wr_merged;
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe0 (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(rd0_en),
    .data_i (old0),
    .valid_o(dout0_valid),
    .data_o (dout0)
  );

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(rd1_en),
    .data_i (rd1_data),
    .valid_o(dout1_valid),
    .data_o (dout1)
  );

endmodule

// File: tb/tb_generic_sram_1rw1r.sv
// Two SRAM configurations driven by the same stimulus: A = 256 words, latency 1, bypass;
// B = 200 words, latency 2, old-data on collision. Each has its own reference memory.
module tb_generic_sram_1rw1r;
  import generic_sram_pkg::*;

  localparam int DEPTH_A = 256, DEPTH_B = 200;
  localparam int LAT_A = 1, LAT_B = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic        a_v0, a_v1, b_v0, b_v1, a_busy, b_busy;
  sram_state_e a_state, b_state;

  generic_sram_1rw1r #(.ADDR_WIDTH(8), .DEPTH(DEPTH_A), .READ_LATENCY(LAT_A),
                       .BYPASS(1'b1), .INIT_ZERO(1'b1)) dut_a (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(a_dout0), .dout0_valid(a_v0), .csb1(csb1), .addr1(addr1),
    .dout1(a_dout1), .dout1_valid(a_v1), .init_busy(a_busy), .dbg_state_o(a_state));

  generic_sram_1rw1r #(.ADDR_WIDTH(8), .DEPTH(DEPTH_B), .READ_LATENCY(LAT_B),
                       .BYPASS(1'b0), .INIT_ZERO(1'b1)) dut_b (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(b_dout0), .dout0_valid(b_v0), .csb1(csb1), .addr1(addr1),
    .dout1(b_dout1), .dout1_valid(b_v1), .init_busy(b_busy), .dbg_state_o(b_state));

  int checks = 0, failures = 0;
  int cyc = 0, rst_edge_mon = 0;
  logic rst_smp = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst;
    if (rst) rst_edge_mon <= cyc + 1;
  end

  function automatic int dep(input int d); return (d == 0) ? DEPTH_A : DEPTH_B; endfunction
  function automatic int lat(input int d); return (d == 0) ? LAT_A : LAT_B; endfunction
  function automatic bit byp(input int d); return d == 0; endfunction

  // reference model and scoreboard: entries are {due cycle, data}
  logic [31:0] mdl [2][256];
  int          last_rst [2];
  logic [63:0] q_a0[$], q_a1[$], q_b0[$], q_b1[$];
  logic [31:0] last_out [4];
  string       pname [4] = '{"a_port0", "a_port1", "b_port0", "b_port1"};

  task automatic push(input int id, input logic [63:0] e);
    case (id)
      0: q_a0.push_back(e);
      1: q_a1.push_back(e);
      2: q_b0.push_back(e);
      default: q_b1.push_back(e);
    endcase
  endtask

  task automatic model_step();
    int n, a0i, a1i;
    logic [31:0] o0, o1, mrg;
    bit wr;
    n   = cyc + 1;
    a0i = int'(addr0);
    a1i = int'(addr1);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        last_rst[d] = n;
        for (int a = 0; a < 256; a++) mdl[d][a] = 32'h0;
      end else if (n > last_rst[d] + dep(d)) begin
        o0  = (a0i < dep(d)) ? mdl[d][a0i] : 32'h0;
        o1  = (a1i < dep(d)) ? mdl[d][a1i] : 32'h0;
        wr  = !csb0 && !web0 && (a0i < dep(d));
        mrg = o0;
        for (int l = 0; l < 4; l++) if (wmask0[l]) mrg[l*8 +: 8] = din0[l*8 +: 8];
        if (!csb0 && web0) push(d * 2, {32'(cyc + lat(d)), o0});
        if (!csb1) push(d * 2 + 1, {32'(cyc + lat(d)), (wr && a1i == a0i && byp(d)) ? mrg : o1});
        if (wr) mdl[d][a0i] = mrg;
      end
    end
  endtask

  // monitor: decoupled from the driver, compares every cycle on the falling edge
  task automatic chk_busy(input int d, input logic b);
    logic e;
    e = (cyc < rst_edge_mon + dep(d));
    checks++;
    if (b !== e) begin
      failures++;
      $display("FAIL init_busy_%0d cyc=%0d got=%b exp=%b", d, cyc, b, e);
    end
  endtask

  task automatic chk_port(input int id, input logic v, input logic [31:0] dat);
    logic [63:0] e;
    bit have;
    have = 0;
    e    = '0;
    checks++;
    if (rst_smp) begin
      if (v !== 1'b0 || dat !== 32'h0) begin
        failures++;
        $display("FAIL %s_rst_clear cyc=%0d got v=%b d=%h exp v=0 d=0", pname[id], cyc, v, dat);
      end
      last_out[id] = 32'h0;
    end else if (v === 1'b1) begin
      case (id)
        0: if (q_a0.size() > 0) begin e = q_a0.pop_front(); have = 1; end
        1: if (q_a1.size() > 0) begin e = q_a1.pop_front(); have = 1; end
        2: if (q_b0.size() > 0) begin e = q_b0.pop_front(); have = 1; end
        default: if (q_b1.size() > 0) begin e = q_b1.pop_front(); have = 1; end
      endcase
      if (!have) begin
        failures++;
        $display("FAIL %s_unexpected_valid cyc=%0d got d=%h exp no valid", pname[id], cyc, dat);
      end else if (dat !== e[31:0] || cyc != int'(e[63:32])) begin
        failures++;
        $display("FAIL %s_read got %h@cyc%0d exp %h@cyc%0d", pname[id], dat, cyc, e[31:0],
                 int'(e[63:32]));
      end
      last_out[id] = dat;
    end else if (v !== 1'b0 || dat !== last_out[id]) begin
      failures++;
      $display("FAIL %s_hold cyc=%0d got v=%b d=%h exp v=0 d=%h", pname[id], cyc, v, dat,
               last_out[id]);
    end
  endtask

  always @(negedge clk) begin
    chk_busy(0, a_busy);
    chk_busy(1, b_busy);
    chk_port(0, a_v0, a_dout0);
    chk_port(1, a_v1, a_dout1);
    chk_port(2, b_v0, b_dout0);
    chk_port(3, b_v1, b_dout1);
  end

  // driver tasks
  task automatic apply(input logic r, input logic c0, input logic w0, input logic [3:0] m,
                       input logic [7:0] a0, input logic [31:0] d0, input logic c1,
                       input logic [7:0] a1);
    rst = r; csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
    model_step();
  endtask

  task automatic step(input logic r, input logic c0, input logic w0, input logic [3:0] m,
                      input logic [7:0] a0, input logic [31:0] d0, input logic c1,
                      input logic [7:0] a1);
    @(posedge clk);
    #2;
    apply(r, c0, w0, m, a0, d0, c1, a1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0, 1'b1, 8'h0);
  endtask

  task automatic chk_empty(input int id, input int sz);
    checks++;
    if (sz != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d pending reads exp 0", pname[id], sz);
    end
  endtask

  initial begin
    logic [7:0] ra0, ra1;
    apply(1'b1, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0, 1'b1, 8'h0);
    repeat (2) step(1'b1, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0, 1'b1, 8'h0);
    // sweep, a port-1 read that must be ignored, then a reset at sweep count 100
    idle(50);
    step(1'b0, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0, 1'b0, 8'h7F);
    idle(49);
    step(1'b1, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0, 1'b1, 8'h0);
    idle(262);
    // zero-filled word, masked write, collision, out-of-range on B
    step(1'b0, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0, 1'b0, 8'h7F);
    step(1'b0, 1'b0, 1'b0, 4'hF, 8'h10, 32'h11223344, 1'b1, 8'h0);
    step(1'b0, 1'b0, 1'b0, 4'b0101, 8'h10, 32'hDEADBEEF, 1'b1, 8'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h0);
    step(1'b0, 1'b0, 1'b0, 4'hF, 8'h20, 32'hCAFEF00D, 1'b0, 8'h20);
    step(1'b0, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0, 1'b0, 8'h20);
    step(1'b0, 1'b0, 1'b0, 4'h0, 8'h30, 32'h55555555, 1'b0, 8'h30);
    step(1'b0, 1'b0, 1'b0, 4'hF, 8'hC8, 32'hFFFFFFFF, 1'b1, 8'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0, 8'hC8, 32'h0, 1'b0, 8'hC8);
    step(1'b0, 1'b0, 1'b1, 4'h0, 8'hC7, 32'h0, 1'b0, 8'h48);
    idle(3);
    // streaming reads of 0..15 on both ports
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 4'hF, 8'(i), $urandom, 1'b1, 8'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 4'h0, 8'(i), 32'h0, 1'b0, 8'(i));
    idle(3);
    // random traffic with a bias toward a small address window for collisions
    for (int i = 0; i < 400; i++) begin
      ra0 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 8'($urandom_range(0, 31));
      step(1'b0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ra0, $urandom, $urandom_range(0, 3) == 0, ra1);
    end
    idle(6);
    chk_empty(0, q_a0.size());
    chk_empty(1, q_a1.size());
    chk_empty(2, q_b0.size());
    chk_empty(3, q_b1.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
